// File: rtl/wb_pkg.sv
// Shared constants and encodings for the write-back port arbiter and its helpers.
package wb_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  typedef enum logic {
    WB_NORMAL = 1'b0,
    WB_FORCE  = 1'b1
  } wb_state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_PIPE = 2'd1,
    SRC_SEC  = 2'd2
  } wb_src_e;

endpackage

// File: rtl/wb_result_mux.sv
// Memory/ALU result select for the write-back stage; also reused by the forwarding unit.
module wb_result_mux #(
  parameter int W = 16
) (
  input  logic         i_mem_or_reg,
  input  logic [W-1:0] i_mem_data,
  input  logic [W-1:0] i_alu_data,
  output logic [W-1:0] o_result
);

  assign o_result = i_mem_or_reg ? i_mem_data : i_alu_data;

endmodule

// File: rtl/wb_port_arbiter.sv
// Owns the register-file write port: pipeline has priority, a secondary writer is
// force-granted after MAX_WAIT consecutive refusals. Write outputs are registered.
module wb_port_arbiter #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_wb_en,
  input  logic              pipe_mem_or_reg,
  input  logic [DATA_W-1:0] pipe_mem_data,
  input  logic [DATA_W-1:0] pipe_alu_data,
  input  logic [ADDR_W-1:0] pipe_rd,
  input  logic              sec_valid,
  input  logic [ADDR_W-1:0] sec_rd,
  input  logic [DATA_W-1:0] sec_data,
  output logic              sec_ready,
  output logic              stall_pipe,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata
);

  import wb_pkg::*;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  wb_state_e         r_state;
  wb_state_e         w_state_nxt;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              w_sec_ready;
  wb_src_e           w_src;
  logic [DATA_W-1:0] w_pipe_result;

  wb_result_mux #(
    .W(DATA_W)
  ) u_result_mux (
    .i_mem_or_reg (pipe_mem_or_reg),
    .i_mem_data   (pipe_mem_data),
    .i_alu_data   (pipe_alu_data),
    .o_result     (w_pipe_result)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= WB_NORMAL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: FORCE lasts exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WB_NORMAL: begin
        if (sec_valid && !w_sec_ready && (r_wait_cnt == WAIT_LAST)) begin
          w_state_nxt = WB_FORCE;
        end else begin
          w_state_nxt = WB_NORMAL;
        end
      end
      WB_FORCE: w_state_nxt = WB_NORMAL;
      default:  w_state_nxt = WB_NORMAL;
    endcase
  end

  // Output logic: handshake, stall and source selection.
  always_comb begin
    stall_pipe  = 1'b0;
    w_sec_ready = 1'b0;
    w_src       = SRC_NONE;
    case (r_state)
      WB_NORMAL: w_sec_ready = sec_valid & ~pipe_wb_en;
      WB_FORCE: begin
        stall_pipe  = 1'b1;
        w_sec_ready = sec_valid;
      end
      default: begin
        stall_pipe  = 1'b0;
        w_sec_ready = 1'b0;
      end
    endcase
    // An in-flight grant is dropped while reset is high; the secondary retries.
    if (rst) begin
      w_sec_ready = 1'b0;
    end else begin
      w_sec_ready = w_sec_ready;
    end
    if (w_sec_ready) begin
      w_src = SRC_SEC;
    end else if ((r_state == WB_NORMAL) && pipe_wb_en) begin
      w_src = SRC_PIPE;
    end else begin
      w_src = SRC_NONE;
    end
  end

  assign sec_ready = w_sec_ready;

  // Consecutive-refusal counter, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if ((r_state == WB_FORCE) || !sec_valid || w_sec_ready) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != {CNT_W{1'b1}}) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end else begin
      r_wait_cnt <= r_wait_cnt;
    end
  end

  // Registered write port; address/data hold when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_addr  <= '0;
      rf_wdata <= '0;
    end else begin
      case (w_src)
        SRC_PIPE: begin
          rf_we    <= 1'b1;
          rf_addr  <= pipe_rd;
          rf_wdata <= w_pipe_result;
        end
        SRC_SEC: begin
          rf_we    <= 1'b1;
          rf_addr  <= sec_rd;
          rf_wdata <= sec_data;
        end
        default: begin
          rf_we    <= 1'b0;
          rf_addr  <= rf_addr;
          rf_wdata <= rf_wdata;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed and randomized checks of wb_port_arbiter against a cycle-level behavioural model.
module tb_wb_port_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wb_en;
  logic        pipe_mem_or_reg;
  logic [15:0] pipe_mem_data;
  logic [15:0] pipe_alu_data;
  logic [2:0]  pipe_rd;
  logic        sec_valid;
  logic [2:0]  sec_rd;
  logic [15:0] sec_data;
  logic        sec_ready;
  logic        stall_pipe;
  logic        rf_we;
  logic [2:0]  rf_addr;
  logic [15:0] rf_wdata;

  int checks = 0;
  int failures = 0;

  // Model: how many cycles the pending secondary request has been refused in a row,
  // whether this cycle is a forced-grant cycle, and the expected write-port state.
  int          m_refused;
  bit          m_force;
  bit          m_ready;
  bit          m_we;
  logic [2:0]  m_addr;
  logic [15:0] m_data;
  logic [15:0] m_rf [8];
  logic [15:0] d_rf [8];

  wb_port_arbiter #(.DATA_W(16), .ADDR_W(3), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .pipe_wb_en(pipe_wb_en), .pipe_mem_or_reg(pipe_mem_or_reg),
    .pipe_mem_data(pipe_mem_data), .pipe_alu_data(pipe_alu_data), .pipe_rd(pipe_rd),
    .sec_valid(sec_valid), .sec_rd(sec_rd), .sec_data(sec_data), .sec_ready(sec_ready),
    .stall_pipe(stall_pipe), .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs are already driven; check combinational outputs, clock, check write port.
  task automatic cycle();
    bit g_sec, g_pipe;
    #1;
    m_ready = !rst && sec_valid && (m_force || !pipe_wb_en);
    chk("sec_ready", sec_ready, m_ready);
    chk("stall_pipe", stall_pipe, m_force);
    g_sec  = m_ready;
    g_pipe = !rst && !m_force && pipe_wb_en && !g_sec;
    @(posedge clk);
    #1;
    if (rst) begin
      m_we = 0; m_addr = 3'd0; m_data = 16'h0000;
      m_force = 0; m_refused = 0;
    end else begin
      if (g_sec) begin
        m_we = 1; m_addr = sec_rd; m_data = sec_data;
      end else if (g_pipe) begin
        m_we = 1; m_addr = pipe_rd;
        m_data = pipe_mem_or_reg ? pipe_mem_data : pipe_alu_data;
      end else begin
        m_we = 0;
      end
      if (sec_valid && !m_ready && !m_force) begin
        m_refused = m_refused + 1;
        m_force = (m_refused == MAX_WAIT);
      end else begin
        m_refused = 0;
        m_force = 0;
      end
      if (m_we) m_rf[m_addr] = m_data;
    end
    chk("rf_we", rf_we, m_we);
    chk("rf_addr", rf_addr, m_addr);
    chk("rf_wdata", rf_wdata, m_data);
    if (rf_we === 1'b1) d_rf[rf_addr] = rf_wdata;
  endtask

  task automatic drive(input bit p_en, input bit p_mr, input logic [15:0] p_mem,
                       input logic [15:0] p_alu, input logic [2:0] p_rd,
                       input bit s_v, input logic [2:0] s_rd, input logic [15:0] s_d);
    pipe_wb_en = p_en; pipe_mem_or_reg = p_mr; pipe_mem_data = p_mem;
    pipe_alu_data = p_alu; pipe_rd = p_rd;
    sec_valid = s_v; sec_rd = s_rd; sec_data = s_d;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      m_rf[i] = 16'h0000;
      d_rf[i] = 16'h0000;
    end
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 3'd0, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("por_rf_we", rf_we, 0);
    chk("por_rf_addr", rf_addr, 0);
    chk("por_rf_wdata", rf_wdata, 0);
    chk("por_stall", stall_pipe, 0);
    chk("por_ready", sec_ready, 0);
    m_refused = 0; m_force = 0; m_we = 0; m_addr = 3'd0; m_data = 16'h0;
    rst = 1'b0;

    // Reset while a pipeline write is presented.
    drive(1'b1, 1'b0, 16'h0, 16'h1234, 3'd5, 1'b0, 3'd0, 16'h0);
    cycle();
    chk("pre_rst_wdata", rf_wdata, 16'h1234);
    rst = 1'b1;
    cycle();
    chk("rst_we", rf_we, 0);
    chk("rst_addr", rf_addr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_stall", stall_pipe, 0);
    rst = 1'b0;

    // Pipeline memory result, then ALU result.
    drive(1'b1, 1'b1, 16'hBEEF, 16'h0001, 3'd3, 1'b0, 3'd0, 16'h0);
    cycle();
    chk("pipe_mem_we", rf_we, 1);
    chk("pipe_mem_addr", rf_addr, 3);
    chk("pipe_mem_data", rf_wdata, 16'hBEEF);
    pipe_mem_or_reg = 1'b0;
    cycle();
    chk("pipe_alu_data", rf_wdata, 16'h0001);

    // Secondary on an idle port.
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b1, 3'd6, 16'h00FF);
    cycle();
    chk("sec_idle_ready", m_ready, 1);
    chk("sec_idle_addr", rf_addr, 6);
    chk("sec_idle_data", rf_wdata, 16'h00FF);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 3'd0, 16'h0);
    cycle();
    chk("idle_hold_data", rf_wdata, 16'h00FF);

    // Starvation: pipeline requests every cycle, secondary valid from cycle 0.
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b0, 16'h0, 16'h7000 + 16'(c), 3'd1, (c < 5), 3'd4, 16'hC0DE);
      #1;
      chk("starve_ready", sec_ready, (c == 4));
      chk("starve_stall", stall_pipe, (c == 4));
      cycle();
      if (c == 4) chk("starve_force_data", rf_wdata, 16'hC0DE);
      if (c == 5) chk("starve_after_data", rf_wdata, 16'h7005);
    end

    // Same-register ordering: pipeline then secondary on R2.
    drive(1'b1, 1'b0, 16'h0, 16'hAAAA, 3'd2, 1'b0, 3'd0, 16'h0);
    cycle();
    chk("order_first", rf_wdata, 16'hAAAA);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b1, 3'd2, 16'h5555);
    cycle();
    chk("order_second", rf_wdata, 16'h5555);
    chk("order_final_r2", d_rf[2], 16'h5555);

    // Randomized traffic; the secondary holds its request until accepted.
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 3'd0, 16'h0);
    m_ready = 0;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      pipe_wb_en = ($urandom_range(0, 3) != 0);
      pipe_mem_or_reg = $urandom_range(0, 1);
      pipe_mem_data = 16'($urandom);
      pipe_alu_data = 16'($urandom);
      pipe_rd = 3'($urandom);
      if (!(sec_valid && !m_ready)) begin
        sec_valid = ($urandom_range(0, 1) == 1);
        sec_rd = 3'($urandom);
        sec_data = 16'($urandom);
      end
      cycle();
    end
    rst = 1'b0;

    for (int r = 0; r < 8; r++) chk("final_rf", d_rf[r], m_rf[r]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Owns the single register-file write port at the write-back end of the 16-bit pipeline.
- Selects the pipeline result: memory data when pipe_mem_or_reg=1, otherwise ALU data.
- Shares the write port with a secondary writer, e.g. a multi-cycle unit or interrupt context restore, using a valid/ready handshake.
- Outputs are registered one cycle before the register file. A bounded-wait counter briefly stalls the pipeline so the secondary writer cannot starve.

Parameters:
- DATA_W, 16, data width of all write data.
- ADDR_W, 3, register address width (R0-R7).
- MAX_WAIT, 4, number of consecutive refused secondary cycles before a forced grant; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- pipe_wb_en  in  1  pipeline write-back request this cycle.
- pipe_mem_or_reg  in  1  1 = write pipe_mem_data, 0 = write pipe_alu_data.
- pipe_mem_data  in  DATA_W  load result.
- pipe_alu_data  in  DATA_W  ALU result.
- pipe_rd  in  ADDR_W  pipeline destination register.
- sec_valid  in  1  secondary write request; held stable until accepted.
- sec_rd  in  ADDR_W  secondary destination register.
- sec_data  in  DATA_W  secondary write data.
- sec_ready  out  1  secondary accepted this cycle (combinational).
- stall_pipe  out  1  freeze the write-back stage register this cycle (Moore, from state).
- rf_we  out  1  registered register-file write enable.
- rf_addr  out  ADDR_W  registered write address.
- rf_wdata  out  DATA_W  registered write data.

Behaviour:
- Reset (rst=1 at a posedge):
  - rf_we=0, rf_addr=0, rf_wdata=0.
  - State returns to NORMAL; wait_cnt=0; stall_pipe=0.
  - sec_ready=0 while rst is high.
  - Reset mid-operation drops any in-flight grant; the secondary must keep sec_valid high and retry.
- FSM states:
  - NORMAL: stall_pipe=0. The pipeline has priority. sec_ready = sec_valid & ~pipe_wb_en.
  - FORCE: stall_pipe=1. The secondary is granted unconditionally: sec_ready = sec_valid. The pipeline request is ignored; upstream holds it, so it is re-presented next cycle and is not lost.
- Transitions:
  - NORMAL -> FORCE when sec_valid & ~sec_ready & (wait_cnt == MAX_WAIT-1).
  - FORCE -> NORMAL always after one cycle.
  - If sec_valid drops while in FORCE, no write occurs that cycle; the state still returns to NORMAL.
- wait_cnt:
  - Increments in NORMAL when sec_valid & ~sec_ready.
  - Clears on any secondary acceptance, when sec_valid=0, or in FORCE.
  - Saturates; it never wraps.
- Write path, one-cycle latency:
  - Grant in cycle N drives rf_we/rf_addr/rf_wdata in cycle N+1.
  - Pipeline grant: rf_wdata = pipe_mem_or_reg ? pipe_mem_data : pipe_alu_data; rf_addr = pipe_rd.
  - Secondary grant: rf_wdata = sec_data; rf_addr = sec_rd.
  - No grant: rf_we=0, and rf_addr/rf_wdata hold their previous values.
- Ordering:
  - Writes reach the register file in grant order.
  - If both writers target the same register, the later grant wins.
  - The arbiter performs no address comparison; hazard resolution belongs upstream.
- At most one write per cycle; rf_we is never asserted for two sources at once.
- No register is special: rd=0 is written like any other.

Decomposition:
- Shared package wb_pkg:
  - DATA_W and ADDR_W constants.
  - State enum {WB_NORMAL, WB_FORCE}.
  - Source-select encoding {SRC_NONE, SRC_PIPE, SRC_SEC}.
- Optional sub-module wb_result_mux: the combinational memory/ALU select, reused by the forwarding unit.
- FSM, counter and output register stay in wb_port_arbiter.

Test Plan:
- Reset during a write:
  - Stimulus: rst=1 while pipe_wb_en=1, rd=5, alu=0x1234.
  - Response: next cycle rf_we=0, rf_addr=0, rf_wdata=0, stall_pipe=0.
- Pipeline, memory result:
  - Stimulus: pipe_wb_en=1, mem_or_reg=1, mem=0xBEEF, alu=0x0001, rd=3.
  - Response: one cycle later rf_we=1, rf_addr=3, rf_wdata=0xBEEF.
- Pipeline, ALU result:
  - Stimulus: same inputs with mem_or_reg=0.
  - Response: rf_wdata=0x0001.
- Secondary on idle port:
  - Stimulus: pipe_wb_en=0, sec_valid=1, sec_rd=6, sec_data=0x00FF.
  - Response: sec_ready=1 the same cycle; next cycle rf_we=1, rf_addr=6, rf_wdata=0x00FF; wait_cnt=0.
- Starvation with MAX_WAIT=4:
  - Stimulus: pipe_wb_en=1 every cycle, sec_valid=1 from cycle 0.
  - Response: sec_ready=0 in cycles 0-3; cycle 4 in FORCE with stall_pipe=1 and sec_ready=1; cycle 5 writes sec_data; cycle 5 back to NORMAL with pipeline granted.
- Same-register ordering:
  - Stimulus: pipeline writes rd=2 with 0xAAAA in cycle N; secondary wins rd=2 with 0x5555 in cycle N+1.
  - Response: rf writes 0xAAAA then 0x5555 on consecutive cycles; the final value is 0x5555.
